eth_hdr_parser: RTL and testbench
=================================

Name: eth_hdr_parser

Overview:
- Sits directly downstream of the AXI-stream ingress boundary and consumes its internal 64-bit stream.
- Forwards every frame beat unchanged to the next stage.
- Extracts the Ethernet L2 header once per frame (dst MAC, src MAC, EtherType, optional single 802.1Q tag) into a metadata side channel with its own valid/ready handshake.
- Flags frames that end before the header is complete.

Parameters:
- DATA_WIDTH, 64, stream width in bits; only 64 is supported (elaboration-time fatal otherwise).
- USER_WIDTH, 1, tuser width; passed through untouched.
- VLAN_TPID, 16'h8100, EtherType value that identifies an 802.1Q tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_tdata  in  64  input beat; byte 0 of the beat is in [7:0]
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  last beat of frame
- s_tuser  in  USER_WIDTH  sideband, forwarded
- m_tdata  out  64  forwarded beat
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  forwarded tlast
- m_tuser  out  USER_WIDTH  forwarded tuser
- meta_valid  out  1  header metadata valid
- meta_ready  in  1  metadata accepted
- meta_dst_mac  out  48  frame bytes 0..5; byte 0 in [47:40]
- meta_src_mac  out  48  frame bytes 6..11; byte 6 in [47:40]
- meta_ethertype  out  16  bytes 12..13 if untagged; bytes 16..17 if tagged; first byte in [15:8]
- meta_vlan_valid  out  1  outer EtherType equalled VLAN_TPID
- meta_vlan_tci  out  16  bytes 14..15 when tagged, else 0
- meta_runt  out  1  frame ended before header complete
- frames_parsed  out  32  count of metadata records accepted, wraps at 2^32

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - meta_valid=0; all meta_* fields=0; frames_parsed=0; FSM=B0.
  - m_* are combinational from s_*; they carry no reset value of their own.
- Data path is combinational: m_tdata/m_tlast/m_tuser = s_*.
  - hold = meta_valid && !meta_ready && hdr_done_beat.
  - m_tvalid = s_tvalid && !hold.
  - s_tready = m_tready && !hold.
  - Latency 0 cycles.
  - xfer = s_tvalid && s_tready.
- hdr_done_beat is true on a beat that will complete a metadata record: any beat in B0/B1/B2 with s_tlast=1, B1 with outer EtherType != VLAN_TPID, or any beat in B2.
- FSM advances only on xfer:
  - B0: capture dst_mac (beat bytes 0..5) and src_mac[47:32] (bytes 6..7). tlast → emit record with runt=1, stay B0. Else → B1.
  - B1: capture src_mac[31:0] (bytes 0..3) and ethertype (bytes 4..5).
    - Outer EtherType == VLAN_TPID: capture tci (bytes 6..7), set vlan_valid. tlast → emit with runt=1, ethertype field = VLAN_TPID → B0. Else → B2.
    - Not VLAN: emit with runt=0. tlast → B0. Else → PAY.
  - B2: ethertype = beat bytes 0..1; emit with runt=0. tlast → B0. Else → PAY.
  - PAY: tlast → B0.
- Emit = on that xfer edge, load all meta_* outputs from captured/current-beat values and set meta_valid=1 on the next cycle.
  - Fields not yet captured in a runt record are 0.
  - Capture registers clear at each frame start.
- Metadata handshake:
  - meta_valid stays 1 and meta_* stay stable until meta_valid && meta_ready.
  - The handshake clears meta_valid unless an emit occurs in the same cycle; an emit wins, so meta_valid stays 1 with the new record.
  - frames_parsed increments by 1 on each meta_valid && meta_ready.
- Back-pressure: only the header-completing beat stalls on an unaccepted record. Header beats before it and payload beats never stall on metadata.
- Simultaneous meta_ready and header-completing beat: hold=0, the old record is consumed and the new one is loaded in the same edge.
- Single-beat frame (tlast in B0): the record carries runt=1, dst_mac valid, src_mac[47:32] valid, rest 0.
- Reset mid-frame clears the FSM to B0. Upstream and downstream are reset with the same rst_n; no frame recovery is attempted.
- Assertions, simulation only:
  - m_* stable while m_tvalid && !m_tready.
  - meta_* stable while meta_valid && !meta_ready.
  - FSM state legal.

Test Plan:
- Untagged 3-beat frame; beat0=64'h2211_FFEE_DDCC_BBAA, beat1=64'h7766_0008_5544_3322; meta_ready=1 → meta_dst_mac=AABBCCDDEEFF, meta_src_mac=11223344_5566, meta_ethertype=0800, vlan_valid=0, runt=0; 3 beats out unchanged; frames_parsed=1.
- Tagged frame; beat1 bytes 4..7 = 81 00 00 64, beat2 bytes 0..1 = 86 DD → vlan_valid=1, meta_vlan_tci=0064, meta_ethertype=86DD; record appears only after beat2.
- Single-beat frame with tlast on beat0 → meta_runt=1, meta_ethertype=0, FSM returns to B0; next frame parses normally.
- meta_ready=0 across two back-to-back untagged frames → first record held stable, s_tready=0 on frame 2 beat1 only; raise meta_ready → frame 2 beat1 transfers in that cycle and record 2 is loaded; frames_parsed ends at 2.
- m_tready toggling randomly over a 10-beat frame → m_* stable while stalled, beat order and contents identical to input, exactly one record.
- rst_n=0 for one cycle while in PAY → meta_valid=0, frames_parsed=0, FSM=B0; next beat is treated as frame beat 0.

Source files
------------

// File: rtl/eth_hdr_parser.sv
// Ethernet L2 header parser: forwards a 64-bit stream unchanged and emits one
// metadata record per frame (MACs, EtherType, optional 802.1Q tag, runt flag).
module eth_hdr_parser #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1,
    parameter logic [15:0] VLAN_TPID  = 16'h8100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [USER_WIDTH-1:0] s_tuser,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser,
    output logic                  meta_valid,
    input  logic                  meta_ready,
    output logic [47:0]           meta_dst_mac,
    output logic [47:0]           meta_src_mac,
    output logic [15:0]           meta_ethertype,
    output logic                  meta_vlan_valid,
    output logic [15:0]           meta_vlan_tci,
    output logic                  meta_runt,
    output logic [31:0]           frames_parsed
);

    if (DATA_WIDTH != 64) begin : g_bad_width
        $fatal(1, "eth_hdr_parser supports DATA_WIDTH=64 only");
    end

    typedef enum logic [1:0] {ST_B0, ST_B1, ST_B2, ST_PAY} state_e;

    state_e      state_q;
    logic [47:0] dst_q;
    logic [47:0] src_q;
    logic [15:0] tci_q;

    logic        meta_valid_q;
    logic [47:0] meta_dst_q;
    logic [47:0] meta_src_q;
    logic [15:0] meta_et_q;
    logic        meta_vv_q;
    logic [15:0] meta_tci_q;
    logic        meta_runt_q;
    logic [31:0] frames_q;

    logic [63:0] beat_be;
    logic        outer_vlan_c;
    logic        hdr_done_c;
    logic        hold_c;
    logic        xfer_c;
    logic        emit_c;
    logic [47:0] rec_dst_d;
    logic [47:0] rec_src_d;
    logic [15:0] rec_et_d;
    logic        rec_vv_d;
    logic [15:0] rec_tci_d;
    logic        rec_runt_d;

    // Frame byte order view: beat byte 0 lands in [63:56]
    always_comb begin
        beat_be = '0;
        for (int i = 0; i < 8; i++) begin
            beat_be[63-8*i -: 8] = s_tdata[8*i +: 8];
        end
    end

    assign outer_vlan_c = (beat_be[31:16] == VLAN_TPID);

    // Record that would be emitted by the current beat, and whether it completes one
    always_comb begin
        hdr_done_c = 1'b0;
        rec_dst_d  = '0;
        rec_src_d  = '0;
        rec_et_d   = '0;
        rec_vv_d   = 1'b0;
        rec_tci_d  = '0;
        rec_runt_d = 1'b0;
        case (state_q)
            ST_B0: begin
                hdr_done_c = s_tlast;
                rec_dst_d  = beat_be[63:16];
                rec_src_d  = {beat_be[15:0], 32'h0};
                rec_runt_d = 1'b1;
            end
            ST_B1: begin
                hdr_done_c = s_tlast || !outer_vlan_c;
                rec_dst_d  = dst_q;
                rec_src_d  = {src_q[47:32], beat_be[63:32]};
                if (outer_vlan_c) begin
                    rec_vv_d   = 1'b1;
                    rec_tci_d  = beat_be[15:0];
                    rec_et_d   = VLAN_TPID;
                    rec_runt_d = 1'b1;
                end else begin
                    rec_et_d   = beat_be[31:16];
                end
            end
            ST_B2: begin
                hdr_done_c = 1'b1;
                rec_dst_d  = dst_q;
                rec_src_d  = src_q;
                rec_vv_d   = 1'b1;
                rec_tci_d  = tci_q;
                rec_et_d   = beat_be[63:48];
            end
            default: hdr_done_c = 1'b0;
        endcase
    end

    // Only the header-completing beat waits for the previous record to drain
    assign hold_c   = meta_valid_q && !meta_ready && hdr_done_c;
    assign s_tready = m_tready && !hold_c;
    assign m_tvalid = s_tvalid && !hold_c;
    assign m_tdata  = s_tdata;
    assign m_tlast  = s_tlast;
    assign m_tuser  = s_tuser;
    assign xfer_c   = s_tvalid && s_tready;
    assign emit_c   = xfer_c && hdr_done_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_B0;
            dst_q        <= '0;
            src_q        <= '0;
            tci_q        <= '0;
            meta_valid_q <= 1'b0;
            meta_dst_q   <= '0;
            meta_src_q   <= '0;
            meta_et_q    <= '0;
            meta_vv_q    <= 1'b0;
            meta_tci_q   <= '0;
            meta_runt_q  <= 1'b0;
            frames_q     <= '0;
        end else begin
            if (meta_valid_q && meta_ready) begin
                meta_valid_q <= 1'b0;
                frames_q     <= frames_q + 32'd1;
            end
            if (emit_c) begin
                meta_valid_q <= 1'b1;
                meta_dst_q   <= rec_dst_d;
                meta_src_q   <= rec_src_d;
                meta_et_q    <= rec_et_d;
                meta_vv_q    <= rec_vv_d;
                meta_tci_q   <= rec_tci_d;
                meta_runt_q  <= rec_runt_d;
            end
            if (xfer_c) begin
                case (state_q)
                    ST_B0: begin
                        dst_q   <= beat_be[63:16];
                        src_q   <= {beat_be[15:0], 32'h0};
                        tci_q   <= '0;
                        state_q <= s_tlast ? ST_B0 : ST_B1;
                    end
                    ST_B1: begin
                        src_q[31:0] <= beat_be[63:32];
                        if (outer_vlan_c) tci_q <= beat_be[15:0];
                        state_q <= s_tlast ? ST_B0 : (outer_vlan_c ? ST_B2 : ST_PAY);
                    end
                    ST_B2:   state_q <= s_tlast ? ST_B0 : ST_PAY;
                    default: if (s_tlast) state_q <= ST_B0;
                endcase
            end
        end
    end

    assign meta_valid      = meta_valid_q;
    assign meta_dst_mac    = meta_dst_q;
    assign meta_src_mac    = meta_src_q;
    assign meta_ethertype  = meta_et_q;
    assign meta_vlan_valid = meta_vv_q;
    assign meta_vlan_tci   = meta_tci_q;
    assign meta_runt       = meta_runt_q;
    assign frames_parsed   = frames_q;

`ifndef SYNTHESIS
    a_m_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tlast) && $stable(m_tuser)));
    a_meta_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (meta_valid && !meta_ready) |=> (meta_valid && $stable(meta_dst_mac) && $stable(meta_src_mac)
            && $stable(meta_ethertype) && $stable(meta_vlan_valid) && $stable(meta_vlan_tci)
            && $stable(meta_runt)));
    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state_q inside {ST_B0, ST_B1, ST_B2, ST_PAY});
`endif

endmodule

// File: tb/tb_eth_hdr_parser.sv
// Scoreboard bench for eth_hdr_parser: beats and header records are predicted
// from the driven frames and compared as the DUT hands them over.
module tb_eth_hdr_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [0:0]  s_tuser;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic        meta_valid;
    logic        meta_ready;
    logic [47:0] meta_dst_mac;
    logic [47:0] meta_src_mac;
    logic [15:0] meta_ethertype;
    logic        meta_vlan_valid;
    logic [15:0] meta_vlan_tci;
    logic        meta_runt;
    logic [31:0] frames_parsed;

    always #5 clk = ~clk;

    eth_hdr_parser dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .meta_valid(meta_valid), .meta_ready(meta_ready),
        .meta_dst_mac(meta_dst_mac), .meta_src_mac(meta_src_mac),
        .meta_ethertype(meta_ethertype), .meta_vlan_valid(meta_vlan_valid),
        .meta_vlan_tci(meta_vlan_tci), .meta_runt(meta_runt),
        .frames_parsed(frames_parsed)
    );

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        logic        vv;
        logic [15:0] tci;
        logic        runt;
    } meta_t;

    logic [65:0] out_q[$];
    meta_t       meta_q[$];
    logic [63:0] frame_buf [16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_frames = 0;
    bit          rnd_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int n);
        return frame_buf[n/8][8*(n%8) +: 8];
    endfunction

    // Reference header record derived from frame bytes and frame length
    function automatic meta_t model(input int nb);
        meta_t       m;
        logic [15:0] outer;
        m     = '0;
        m.dst = {fbyte(0), fbyte(1), fbyte(2), fbyte(3), fbyte(4), fbyte(5)};
        if (nb == 1) begin
            m.src  = {fbyte(6), fbyte(7), 32'h0};
            m.runt = 1'b1;
        end else begin
            m.src = {fbyte(6), fbyte(7), fbyte(8), fbyte(9), fbyte(10), fbyte(11)};
            outer = {fbyte(12), fbyte(13)};
            if (outer == 16'h8100) begin
                m.vv  = 1'b1;
                m.tci = {fbyte(14), fbyte(15)};
                if (nb == 2) begin
                    m.et   = 16'h8100;
                    m.runt = 1'b1;
                end else begin
                    m.et = {fbyte(16), fbyte(17)};
                end
            end else begin
                m.et = outer;
            end
        end
        return m;
    endfunction

    task automatic drive_beat(input logic [63:0] d, input bit last);
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = 1'($urandom_range(0, 1));
        s_tvalid = 1'b1;
        out_q.push_back({last, s_tuser, d});
    endtask

    task automatic send_beat(input logic [63:0] d, input bit last);
        bit rdy;
        bit done;
        done = 1'b0;
        drive_beat(d, last);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        if (!done) check_eq("xfer_timeout", 0, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic expect_frame(input int nb);
        meta_q.push_back(model(nb));
        exp_frames++;
    endtask

    task automatic send_frame(input int nb);
        expect_frame(nb);
        for (int i = 0; i < nb; i++) send_beat(frame_buf[i], i == nb - 1);
    endtask

    task automatic fill_rand(input int nb);
        for (int i = 0; i < nb; i++) frame_buf[i] = {$urandom, $urandom};
        frame_buf[1][47:32] = 16'h0008;
    endtask

    task automatic drain();
        meta_ready = 1'b1;
        m_tready   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("meta_q_empty", 128'(meta_q.size()), 0);
        check_eq("frames_parsed", 128'(frames_parsed), 128'(exp_frames));
    endtask

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            m_tready = 1'($urandom_range(0, 1));
        end
    end

    logic [65:0] prev_m;
    meta_t       prev_meta;
    bit          m_stalled = 1'b0;
    bit          meta_stalled = 1'b0;

    // Output-side monitor: pops scoreboards on handshakes, checks stability under stall
    always @(negedge clk) begin
        logic [65:0] e;
        meta_t       em;
        meta_t       cur_meta;
        cur_meta = {meta_dst_mac, meta_src_mac, meta_ethertype, meta_vlan_valid, meta_vlan_tci, meta_runt};
        if (!rst_n) begin
            m_stalled    = 1'b0;
            meta_stalled = 1'b0;
        end else begin
            if (m_stalled) check_eq("m_stable", {m_tvalid, m_tlast, m_tuser, m_tdata}, {1'b1, prev_m});
            if (meta_stalled) check_eq("meta_stable", {meta_valid, cur_meta}, {1'b1, prev_meta});
            if (m_tvalid && m_tready) begin
                if (out_q.size() == 0) check_eq("beat_unexp", 1, 0);
                else begin
                    e = out_q.pop_front();
                    check_eq("m_beat", {m_tlast, m_tuser, m_tdata}, e);
                end
            end
            if (meta_valid && meta_ready) begin
                if (meta_q.size() == 0) check_eq("meta_unexp", 1, 0);
                else begin
                    em = meta_q.pop_front();
                    check_eq("meta_dst", meta_dst_mac, em.dst);
                    check_eq("meta_src", meta_src_mac, em.src);
                    check_eq("meta_et", meta_ethertype, em.et);
                    check_eq("meta_vlan", {meta_vlan_valid, meta_vlan_tci}, {em.vv, em.tci});
                    check_eq("meta_runt", meta_runt, em.runt);
                end
            end
            m_stalled    = m_tvalid && !m_tready;
            prev_m       = {m_tlast, m_tuser, m_tdata};
            meta_stalled = meta_valid && !meta_ready;
            prev_meta    = cur_meta;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
        m_tready = 1'b1; meta_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_meta_valid", meta_valid, 0);
        check_eq("rst_frames", frames_parsed, 0);
        check_eq("rst_meta_fields", {meta_dst_mac, meta_src_mac, meta_ethertype, meta_runt}, 0);
        check_eq("rst_s_tready", s_tready, 1);
        @(posedge clk); #1;

        // Untagged 3-beat frame
        frame_buf[0] = 64'h2211_FFEE_DDCC_BBAA;
        frame_buf[1] = 64'h7766_0008_5544_3322;
        frame_buf[2] = {$urandom, $urandom};
        send_frame(3);
        drain();

        // Tagged frame: record must not appear before the inner EtherType beat
        fill_rand(4);
        frame_buf[1][63:32] = 32'h6400_0081;
        frame_buf[2][15:0]  = 16'hDD86;
        expect_frame(4);
        send_beat(frame_buf[0], 1'b0);
        check_eq("tag_early0", meta_valid, 0);
        send_beat(frame_buf[1], 1'b0);
        check_eq("tag_early1", meta_valid, 0);
        send_beat(frame_buf[2], 1'b0);
        check_eq("tag_rec", {meta_valid, meta_vlan_tci, meta_ethertype}, {1'b1, 16'h0064, 16'h86DD});
        send_beat(frame_buf[3], 1'b1);
        drain();

        // Single-beat runt, then a normal frame; also a tagged 2-beat runt
        fill_rand(1);
        send_frame(1);
        fill_rand(2);
        send_frame(2);
        fill_rand(2);
        frame_buf[1][47:32] = 16'h0081;
        send_frame(2);
        drain();

        // Record held: only frame 2's header-completing beat stalls
        meta_ready = 1'b0;
        fill_rand(3);
        send_frame(3);
        fill_rand(3);
        expect_frame(3);
        send_beat(frame_buf[0], 1'b0);
        drive_beat(frame_buf[1], 1'b0);
        repeat (4) begin
            @(negedge clk);
            check_eq("hold_s_tready", s_tready, 0);
            check_eq("hold_m_tvalid", m_tvalid, 0);
        end
        check_eq("hold_frames", frames_parsed, 128'(exp_frames - 2));
        @(posedge clk); #1;
        meta_ready = 1'b1;
        @(negedge clk);
        check_eq("release_s_tready", s_tready, 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        check_eq("rec2_loaded", meta_valid, 1);
        send_beat(frame_buf[2], 1'b1);
        drain();

        // Random downstream back-pressure over a 10-beat frame
        fill_rand(10);
        rnd_mode = 1'b1;
        send_frame(10);
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk);
        #2 m_tready = 1'b1;
        @(posedge clk); #1;
        drain();
        check_eq("rnd_out_q_empty", 128'(out_q.size()), 0);

        // Reset while in payload
        fill_rand(6);
        expect_frame(6);
        for (int i = 0; i < 4; i++) send_beat(frame_buf[i], 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_frames = 0;
        check_eq("mid_rst_meta_valid", meta_valid, 0);
        check_eq("mid_rst_frames", frames_parsed, 0);
        check_eq("mid_rst_dst", meta_dst_mac, 0);
        fill_rand(3);
        send_frame(3);
        drain();
        check_eq("end_out_q_empty", 128'(out_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
